regfl_rdout: RTL and testbench
==============================

Name: regfl_rdout

Overview:
Read-out stage directly downstream of the 8x64-bit register file.
- Input: the register file's flattened 512-bit contents bus.
- On `start`, takes a snapshot of the bus.
- Streams the registers out, index 0..7, one 64-bit word per beat over a valid/ready handshake.
- Optionally skips zero-valued registers.
- Accumulates a running sum of the words it sends.
- Feeds checksum and debug-dump logic.

Parameters:
- W, 64: register width in bits.
- N, 8: number of registers; must equal 2**AW.
- AW, 3: register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  reset, synchronous, active-low.
- start  input  1  begin a scan; sampled only in IDLE.
- skip_zero  input  1  skip zero-valued registers; latched on the accepted start.
- q  input  N*W  register file contents; register k occupies q[N*W-1-W*k : N*W-W-W*k], so register 0 is the MSB slice.
- busy  output  1  high in SEND and DONE.
- o_valid  output  1  output word valid.
- o_ready  input  1  downstream accepts the word.
- o_idx  output  AW  index of the current word.
- o_data  output  W  current word.
- o_last  output  1  current beat is the final beat of the scan.
- done  output  1  one-cycle pulse at the end of a scan.
- sum  output  W+AW  sum of all words accepted in the current or last scan.

Behaviour:
- Reset: on a rising edge with rst_b=0, all of the following take effect on that edge, and any in-flight scan is aborted with no done pulse:
  - state to IDLE; idx to 0;
  - snapshot buffer and latched skip to 0;
  - sum to 0; done to 0.
  - Consequently o_valid=0, o_idx=0, o_data=0 and o_last=0.
- FSM has three states: IDLE, SEND, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge does all of the following on that edge: snapshot buf<=q, latch skip<=skip_zero, idx<=0, sum<=0, go to SEND.
  - start=0 leaves the state unchanged.
- SEND:
  - busy=1.
  - cur = buf word at idx; zero = (cur==0).
  - o_valid = !(skip && zero).
  - o_data = cur; o_idx = idx.
  - All outputs are decoded from registered state only; there is no combinational input-to-output path.
- SEND transitions:
  - If skip && zero (skip cycle), take a single cycle with no beat: idx<=idx+1, or go to DONE if idx==N-1.
  - Else, if o_ready=1, the beat is accepted: sum<=sum+cur (zero-extended to W+AW bits; the width cannot overflow for N words), then idx<=idx+1, or go to DONE if idx==N-1.
  - Else (o_ready=0): stall; o_valid, o_data and o_idx are held stable. Once raised, o_valid does not drop until the beat is accepted.
- o_last = o_valid && (idx==N-1 || (skip && every buf word above idx is zero)).
  - If skip is set and every word is zero, o_last is never asserted.
- DONE: done=1 for exactly one cycle, busy=1, then return to IDLE. sum holds until the next accepted start or reset.
- Other rules:
  - start while busy is ignored, with no queuing.
  - Changes on q after the snapshot have no effect on the current scan.
  - A start in the IDLE cycle directly after DONE is accepted.
- Latency:
  - start accepted at edge t gives the first o_valid during cycle t+1.
  - With no skips and o_ready held high, the 8 beats occur in cycles t+1..t+8, done is high in cycle t+9, and the block is back in IDLE at t+10.
  - Each skipped register costs exactly one cycle.
  - Each stall cycle adds one cycle.

Test Plan:
1. Reset/idle: rst_b=0 for 2 edges, then 1, with no start -> busy=0, o_valid=0, done=0, sum=0, o_idx=0 throughout.
2. Full scan: registers k hold k+1, skip_zero=0, o_ready=1 -> beats with idx 0..7 and data 1..8 in cycles t+1..t+8; o_last only on idx 7; done at t+9; sum=36.
3. Backpressure: same data, o_ready=0 for 3 cycles while idx=2 -> o_valid=1, o_data=3, o_idx=2 held stable; done at t+12; sum=36.
4. Skip zeros: registers = {0,5,0,0,7,0,0,0}, skip_zero=1 -> exactly 2 beats, (idx1,5) then (idx4,7); o_last on idx4; done at t+9; sum=12. All-zero contents with skip_zero=1 -> no beats, no o_last, done at t+9, sum=0.
5. Snapshot and start-ignore: start, then change q and pulse start mid-scan -> streamed data equals the pre-change snapshot; a single done pulse; scan not restarted.
6. Reset mid-scan: rst_b=0 for one edge while idx=3 -> next cycle state IDLE, o_valid=0, sum=0, and no done pulse.

Source files
------------

// File: rtl/regfl_rdout_if.sv
// regfl_rdout_if: valid/ready word stream carrying register index, data and last flag
interface regfl_rdout_if #(
  parameter int W  = 64,
  parameter int AW = 3
);
  logic          o_valid;
  logic          o_ready;
  logic          o_last;
  logic [AW-1:0] o_idx;
  logic [W-1:0]  o_data;
  modport master (output o_valid, o_idx, o_data, o_last, input o_ready);
  modport slave (input o_valid, o_idx, o_data, o_last, output o_ready);
endinterface

// File: rtl/regfl_rdout.sv
// regfl_rdout: snapshots the register file and streams its words with optional zero skipping and a running sum
module regfl_rdout #(
  parameter int W  = 64,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic            skip_zero,
  input  logic [N*W-1:0]  q,
  output logic            busy,
  output logic            done,
  output logic [W+AW-1:0] sum,
  regfl_rdout_if.master   o
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t             state, nxt;
  logic [0:N-1][W-1:0] snap;
  logic               skip;
  logic [AW-1:0]      idx;
  logic [N-1:0]       nz;
  logic [W-1:0]       cur;
  logic               vld, skp, beat, at_end, rest_zero;
  for (genvar k = 0; k < N; k++) begin : g_nz
    assign nz[k] = |snap[k];
  end
  assign cur       = snap[idx];
  assign at_end    = idx == AW'(N - 1);
  assign rest_zero = ((nz >> idx) >> 1) == '0;
  assign skp       = state == SEND && skip && cur == '0;
  assign vld       = state == SEND && !(skip && cur == '0);
  assign beat      = vld && o.o_ready;
  assign o.o_valid = vld;
  assign o.o_idx   = idx;
  assign o.o_data  = cur;
  assign o.o_last  = vld && (at_end || (skip && rest_zero));
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_comb begin
    nxt = state == IDLE ? (start ? SEND : IDLE) :
          state == SEND ? ((skp || beat) && at_end ? DONE : SEND) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
      skip  <= 1'b0;
      sum   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        snap <= q;
        skip <= skip_zero;
        idx  <= '0;
        sum  <= '0;
      end
      if (skp || beat) idx <= idx + 1'b1;
      if (beat) sum <= sum + (W+AW)'(cur);
    end
  end
endmodule

// File: tb/tb_regfl_rdout.sv
// tb_regfl_rdout: scoreboard bench with directed scenarios and randomized scans against a word-list model
module tb_regfl_rdout;
  localparam int W  = 64;
  localparam int N  = 8;
  localparam int AW = 3;
  typedef struct {
    logic [AW-1:0] idx;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;
  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            start = 1'b0;
  logic            skip_zero = 1'b0;
  logic [N*W-1:0]  q = '0;
  logic            busy, done;
  logic [W+AW-1:0] sum;
  logic            rdy_rand = 1'b0;
  logic            rdy_dir = 1'b1;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  int              done_cnt = 0;
  int              stall_cnt = 0;
  logic            prev_stall = 1'b0;
  logic [AW-1:0]   prev_idx;
  logic [W-1:0]    prev_data;
  beat_t           exp_q[$];
  int              acc_q[$];
  logic [W+AW-1:0] sum_q[$];
  beat_t           mb;
  int              ma;
  logic [W+AW-1:0] ms;
  regfl_rdout_if #(.W(W), .AW(AW)) bus ();
  regfl_rdout #(.W(W), .N(N), .AW(AW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .skip_zero(skip_zero), .q(q),
    .busy(busy), .done(done), .sum(sum), .o(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    bus.o_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_dir;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] word_of(input logic [N*W-1:0] qv, input int k);
    return qv[N*W-1-W*k -: W];
  endfunction
  function automatic logic [W+AW-1:0] model_sum(input logic [N*W-1:0] qv, input logic sk);
    logic [W+AW-1:0] s = '0;
    for (int k = 0; k < N; k++)
      if (!(sk && word_of(qv, k) == '0)) s += (W+AW)'(word_of(qv, k));
    return s;
  endfunction
  task automatic push_scan(input logic [N*W-1:0] qv, input logic sk, input int acc);
    beat_t b;
    int    last_k = -1;
    for (int k = 0; k < N; k++)
      if (!(sk && word_of(qv, k) == '0)) last_k = k;
    for (int k = 0; k < N; k++)
      if (!(sk && word_of(qv, k) == '0)) begin
        b.idx  = AW'(k);
        b.data = word_of(qv, k);
        b.last = k == last_k;
        exp_q.push_back(b);
      end
    acc_q.push_back(acc);
    sum_q.push_back(model_sum(qv, sk));
  endtask
  task automatic start_scan(input logic [N*W-1:0] qv, input logic sk, output int acc);
    q         = qv;
    skip_zero = sk;
    start     = 1'b1;
    acc       = cyc + 1;
    push_scan(qv, sk, acc);
    tick();
    start     = 1'b0;
  endtask
  task automatic wait_done(input int exp_cyc, input logic [W+AW-1:0] exp_sum);
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
    chk("done_seen", done, 1);
    if (exp_cyc >= 0) chk("done_cycle_direct", cyc, exp_cyc);
    chk("sum_final", sum, exp_sum);
    tick();
    chk("idle_after_done", busy, 0);
  endtask
  always @(negedge clk) begin
    if (rst_b !== 1'b1) begin
      stall_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_idx", bus.o_idx, prev_idx);
        chk("hold_data", bus.o_data, prev_data);
      end
      if (bus.o_last === 1'b1 && bus.o_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL last_without_valid: o_last=1 with o_valid=%b", bus.o_valid);
      end
      if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: idx %0d data %0h, no beat expected", bus.o_idx, bus.o_data);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_idx", bus.o_idx, mb.idx);
          chk("beat_data", bus.o_data, mb.data);
          chk("beat_last", bus.o_last, mb.last);
        end
      end
      prev_stall = bus.o_valid === 1'b1 && bus.o_ready !== 1'b1;
      prev_idx   = bus.o_idx;
      prev_data  = bus.o_data;
      if (prev_stall) stall_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, no scan pending", cyc);
        end else begin
          ma = acc_q.pop_front();
          ms = sum_q.pop_front();
          chk("done_cycle", cyc, ma + N + stall_cnt);
          chk("done_sum", sum, ms);
          chk("beats_left_at_done", exp_q.size(), 0);
        end
        stall_cnt = 0;
      end
    end
  end
  initial begin
    logic [W-1:0]   w [N];
    logic [N*W-1:0] qv, qa;
    logic           sk;
    int             acc, d0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_idx", bus.o_idx, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_last", bus.o_last, 0);
    rst_b = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_valid", bus.o_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_sum", sum, 0);
      chk("idle_idx", bus.o_idx, 0);
    end
    for (int k = 0; k < N; k++) qv[N*W-1-W*k -: W] = W'(k + 1);
    start_scan(qv, 1'b0, acc);
    chk("first_valid", bus.o_valid, 1);
    chk("first_idx", bus.o_idx, 0);
    chk("first_data", bus.o_data, 1);
    wait_done(acc + 8, 36);
    start_scan(qv, 1'b0, acc);
    for (int i = 0; i < 20 && !(bus.o_valid === 1'b1 && bus.o_idx == 2); i++) tick();
    rdy_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", bus.o_valid, 1);
      chk("bp_data", bus.o_data, 3);
      chk("bp_idx", bus.o_idx, 2);
      tick();
    end
    rdy_dir = 1'b1;
    wait_done(acc + 11, 36);
    qv = '0;
    qv[N*W-1-W*1 -: W] = 64'd5;
    qv[N*W-1-W*4 -: W] = 64'd7;
    start_scan(qv, 1'b1, acc);
    wait_done(acc + 8, 12);
    start_scan('0, 1'b1, acc);
    wait_done(acc + 8, 0);
    qa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d0 = done_cnt;
    start_scan(qa, 1'b0, acc);
    repeat (3) tick();
    q     = ~qa;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(acc + 8, model_sum(qa, 1'b0));
    repeat (12) tick();
    chk("single_done", done_cnt - d0, 1);
    chk("no_restart_busy", busy, 0);
    start_scan(qv, 1'b0, acc);
    for (int i = 0; i < 20 && !(bus.o_valid === 1'b1 && bus.o_idx == 3); i++) tick();
    chk("pre_reset_idx", bus.o_idx, 3);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    exp_q.delete();
    acc_q.delete();
    sum_q.delete();
    d0 = done_cnt;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_idx", bus.o_idx, 0);
    repeat (12) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    rdy_rand = 1'b1;
    for (int s = 0; s < 25; s++) begin
      for (int k = 0; k < N; k++) w[k] = $urandom_range(0, 1) == 0 ? '0 : {$urandom, $urandom};
      for (int k = 0; k < N; k++) qv[N*W-1-W*k -: W] = w[k];
      sk = 1'($urandom_range(0, 1));
      start_scan(qv, sk, acc);
      wait_done(-1, model_sum(qv, sk));
    end
    rdy_rand = 1'b0;
    repeat (4) tick();
    chk("beats_left_end", exp_q.size(), 0);
    chk("dones_left_end", acc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
